// File: rtl/programmed_offsets_incrementing.sv
`default_nettype none
// ============================================================================
// Module  : programmed_offsets_incrementing
// Brief   : Per-thread address offset with signed post-increment, 2-cycle latency
// Revision: 1.0 - initial release
// ============================================================================
module programmed_offsets_incrementing #(
   parameter int WORD_WIDTH        = 10,
   parameter int INCR_WIDTH        = 4,
   parameter int THREAD_COUNT      = 8,
   parameter int THREAD_ADDR_WIDTH = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cfg_wren,
   input  logic                         cfg_sel,
   input  logic [THREAD_ADDR_WIDTH-1:0] cfg_thread,
   input  logic [WORD_WIDTH-1:0]        cfg_data,
   input  logic                         in_valid,
   input  logic [THREAD_ADDR_WIDTH-1:0] in_thread,
   input  logic                         in_post_inc,
   output logic [WORD_WIDTH-1:0]        offset,
   output logic                         offset_valid
);

   logic [WORD_WIDTH-1:0]        r_off_mem [THREAD_COUNT];
   logic [INCR_WIDTH-1:0]        r_inc_mem [THREAD_COUNT];

   logic                         r_s1_valid;
   logic                         r_s1_post_inc;
   logic [THREAD_ADDR_WIDTH-1:0] r_s1_thread;
   logic [WORD_WIDTH-1:0]        r_s1_offset;
   logic [INCR_WIDTH-1:0]        r_s1_incr;

   logic [WORD_WIDTH-1:0]        r_out_offset;
   logic                         r_out_valid;

   logic [WORD_WIDTH-1:0]        w_next;
   logic                         w_wb_en;
   logic                         w_cfg_off_we;
   logic                         w_cfg_inc_we;
   logic [WORD_WIDTH-1:0]        w_rd_off;
   logic [INCR_WIDTH-1:0]        w_rd_inc;

   function automatic logic f_in_range(input logic [THREAD_ADDR_WIDTH-1:0] thr);
      return ({{(32-THREAD_ADDR_WIDTH){1'b0}}, thr} < THREAD_COUNT);
   endfunction

   assign w_next       = r_s1_offset + {{(WORD_WIDTH-INCR_WIDTH){r_s1_incr[INCR_WIDTH-1]}}, r_s1_incr};
   assign w_wb_en      = r_s1_valid & r_s1_post_inc & f_in_range(r_s1_thread);
   assign w_cfg_off_we = cfg_wren & ~cfg_sel & f_in_range(cfg_thread);
   assign w_cfg_inc_we = cfg_wren &  cfg_sel & f_in_range(cfg_thread);

   // Write-first read: later assignments win, so cfg write outranks the writeback.
   always_comb begin
      w_rd_off = '0;
      w_rd_inc = '0;
      if (f_in_range(in_thread)) begin
         w_rd_off = r_off_mem[in_thread];
         w_rd_inc = r_inc_mem[in_thread];
         if (w_wb_en && (r_s1_thread == in_thread))
            w_rd_off = w_next;
         if (w_cfg_off_we && (cfg_thread == in_thread))
            w_rd_off = cfg_data;
         if (w_cfg_inc_we && (cfg_thread == in_thread))
            w_rd_inc = cfg_data[INCR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int t = 0; t < THREAD_COUNT; t++) begin
            r_off_mem[t] <= '0;
            r_inc_mem[t] <= '0;
         end
         r_s1_valid    <= 1'b0;
         r_s1_post_inc <= 1'b0;
         r_s1_thread   <= '0;
         r_s1_offset   <= '0;
         r_s1_incr     <= '0;
         r_out_offset  <= '0;
         r_out_valid   <= 1'b0;
      end else begin
         for (int t = 0; t < THREAD_COUNT; t++) begin
            if (w_cfg_off_we && (cfg_thread == THREAD_ADDR_WIDTH'(t)))
               r_off_mem[t] <= cfg_data;
            else if (w_wb_en && (r_s1_thread == THREAD_ADDR_WIDTH'(t)))
               r_off_mem[t] <= w_next;
            if (w_cfg_inc_we && (cfg_thread == THREAD_ADDR_WIDTH'(t)))
               r_inc_mem[t] <= cfg_data[INCR_WIDTH-1:0];
         end
         r_s1_valid    <= in_valid;
         r_s1_post_inc <= in_post_inc;
         r_s1_thread   <= in_thread;
         r_s1_offset   <= w_rd_off;
         r_s1_incr     <= w_rd_inc;
         // Output holds its last value across idle cycles; only the valid drops.
         if (r_s1_valid)
            r_out_offset <= r_s1_offset;
         r_out_valid   <= r_s1_valid;
      end
   end

   assign offset       = r_out_offset;
   assign offset_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_programmed_offsets_incrementing.sv
`default_nettype none
// ============================================================================
// Module  : tb_programmed_offsets_incrementing
// Brief   : Directed self-checking bench for programmed_offsets_incrementing
// Revision: 1.0 - initial release
// ============================================================================
module tb_programmed_offsets_incrementing;

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_wren;
   logic       cfg_sel;
   logic [2:0] cfg_thread;
   logic [9:0] cfg_data;
   logic       in_valid;
   logic [2:0] in_thread;
   logic       in_post_inc;
   logic [9:0] offset;
   logic       offset_valid;

   int checks = 0;
   int errors = 0;

   logic       p_v    = 1'b0;
   logic [9:0] p_o    = '0;
   logic [9:0] m_last = '0;

   programmed_offsets_incrementing #(
      .WORD_WIDTH(10), .INCR_WIDTH(4), .THREAD_COUNT(8), .THREAD_ADDR_WIDTH(3)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_wren(cfg_wren), .cfg_sel(cfg_sel), .cfg_thread(cfg_thread), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_thread(in_thread), .in_post_inc(in_post_inc),
      .offset(offset), .offset_valid(offset_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one cycle; exp_o is the value this cycle's request must produce two edges later.
   task automatic step(input logic v, input logic [2:0] thr, input logic post,
                       input logic wren, input logic sel, input logic [2:0] cthr,
                       input logic [9:0] cdata, input logic [9:0] exp_o, input string tag);
      in_valid = v; in_thread = thr; in_post_inc = post;
      cfg_wren = wren; cfg_sel = sel; cfg_thread = cthr; cfg_data = cdata;
      @(posedge clock); #1;
      if (p_v) m_last = p_o;
      chk({tag, "_valid"}, {9'd0, offset_valid}, {9'd0, p_v});
      chk({tag, "_offset"}, offset, m_last);
      p_v = v;
      p_o = exp_o;
   endtask

   task automatic req(input logic [2:0] thr, input logic post, input logic [9:0] exp_o, input string tag);
      step(1'b1, thr, post, 1'b0, 1'b0, 3'd0, 10'd0, exp_o, tag);
   endtask

   task automatic cfg(input logic sel, input logic [2:0] thr, input logic [9:0] data, input string tag);
      step(1'b0, 3'd0, 1'b0, 1'b1, sel, thr, data, 10'd0, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 10'd0, tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      in_valid = 1'b1; in_thread = 3'd3; in_post_inc = 1'b1;
      cfg_wren = 1'b1; cfg_sel = 1'b0; cfg_thread = 3'd1; cfg_data = 10'h123;
      @(posedge clock); #1;
      chk({tag, "_valid"}, {9'd0, offset_valid}, 10'd0);
      chk({tag, "_offset"}, offset, 10'd0);
      p_v = 1'b0; p_o = '0; m_last = '0;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      do_reset("rst0");
      do_reset("rst1");

      for (int t = 0; t < 8; t++) req(3'(t), 1'b0, 10'h000, "zero_rd");
      idle("zero_rd_tail0");
      idle("zero_rd_tail1");

      cfg(1'b0, 3'd3, 10'h100, "t3_cfg_off");
      cfg(1'b1, 3'd3, 10'h001, "t3_cfg_inc");
      req(3'd3, 1'b1, 10'h100, "t3_inc0");
      req(3'd3, 1'b1, 10'h101, "t3_inc1");
      req(3'd3, 1'b1, 10'h102, "t3_inc2");
      req(3'd3, 1'b1, 10'h103, "t3_inc3");
      req(3'd3, 1'b0, 10'h104, "t3_final");
      idle("t3_tail0");
      idle("t3_tail1");

      cfg(1'b0, 3'd5, 10'h001, "t5_cfg_off");
      cfg(1'b1, 3'd5, 10'h00E, "t5_cfg_inc");
      req(3'd5, 1'b1, 10'h001, "t5_dec0");
      req(3'd5, 1'b1, 10'h3FF, "t5_wrap");
      req(3'd5, 1'b0, 10'h3FD, "t5_final");
      idle("t5_tail0");

      cfg(1'b0, 3'd2, 10'h010, "t2_cfg_off");
      cfg(1'b1, 3'd2, 10'h001, "t2_cfg_inc");
      req(3'd2, 1'b1, 10'h010, "t2_req");
      cfg(1'b0, 3'd2, 10'h050, "t2_collide");
      req(3'd2, 1'b0, 10'h050, "t2_after");
      idle("t2_tail0");

      // Cfg write forwarded into a same-edge capture.
      step(1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd4, 10'h2AA, 10'h2AA, "t4_fwd");
      idle("t4_hold0");
      idle("t4_hold1");

      req(3'd3, 1'b1, 10'h104, "inflight0");
      req(3'd3, 1'b1, 10'h105, "inflight1");
      do_reset("rst_mid");
      req(3'd3, 1'b0, 10'h000, "post_rst_t3");
      req(3'd1, 1'b0, 10'h000, "post_rst_t1");
      req(3'd5, 1'b0, 10'h000, "post_rst_t5");
      idle("post_rst_tail0");
      idle("post_rst_tail1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
